// File: rtl/ov7670_pixel_capture_if.sv
// OV7670 capture bus: camera-side inputs plus the tagged-pixel and frame-status outputs.
interface ov7670_pixel_capture_if #(
    parameter int ADDR_W = 19
);
    logic              enable;
    logic              vsync;
    logic              href;
    logic [7:0]        p_data;
    logic [15:0]       pixel_data;
    logic              pixel_valid;
    logic [10:0]       pixel_x;
    logic [10:0]       pixel_y;
    logic [ADDR_W-1:0] pixel_addr;
    logic              frame_done;
    logic              frame_err;
    logic [7:0]        frame_count;
    logic              busy;

    modport slave (
        input  enable, vsync, href, p_data,
        output pixel_data, pixel_valid, pixel_x, pixel_y, pixel_addr,
        output frame_done, frame_err, frame_count, busy
    );

    modport master (
        output enable, vsync, href, p_data,
        input  pixel_data, pixel_valid, pixel_x, pixel_y, pixel_addr,
        input  frame_done, frame_err, frame_count, busy
    );
endinterface

// File: rtl/ov7670_pixel_capture.sv
// OV7670 frame-gated capture: pairs bus bytes into RGB565 pixels tagged with x/y/address,
// and reports frame completion with a sticky geometry error flag.
module ov7670_pixel_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic                   p_clk,
    input  logic                   rst_n,
    ov7670_pixel_capture_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [10:0]       X_END    = 11'(H_ACTIVE);
    localparam logic [10:0]       Y_END    = 11'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(H_ACTIVE * V_ACTIVE);

    logic [1:0]        state_q, state_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic [10:0]       x_q, x_d;
    logic [10:0]       y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [15:0]       pixel_data_q, pixel_data_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic [10:0]       pixel_x_q, pixel_x_d;
    logic [10:0]       pixel_y_q, pixel_y_d;
    logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic              busy_q, busy_d;

    logic vsync_rise_s;
    logic vsync_fall_s;
    logic line_end_s;

    assign vsync_rise_s = bus.vsync & ~vsync_q;
    assign vsync_fall_s = ~bus.vsync & vsync_q;
    assign line_end_s   = href_q & ~bus.href;

    // Next-state logic: frame gating FSM, byte pairing, line/frame geometry tracking.
    always_comb begin
        state_d       = state_q;
        vsync_d       = bus.vsync;
        href_d        = bus.href;
        phase_d       = phase_q;
        hi_byte_d     = hi_byte_q;
        x_d           = x_q;
        y_d           = y_q;
        addr_d        = addr_q;
        err_d         = err_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        pixel_addr_d  = pixel_addr_q;
        frame_done_d  = 1'b0;
        frame_err_d   = frame_err_q;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (vsync_fall_s) begin
                    state_d     = ST_ACTIVE;
                    x_d         = 11'd0;
                    y_d         = 11'd0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    err_d       = 1'b0;
                    frame_err_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACTIVE: begin
                // Line end is folded in first so a coincident vsync rise sees the updated y/err.
                if (line_end_s) begin
                    err_d   = err_q | phase_q | (x_q != X_END);
                    x_d     = 11'd0;
                    phase_d = 1'b0;
                    y_d     = (y_q >= Y_END) ? Y_END : (y_q + 11'd1);
                end else begin
                    x_d = x_q;
                end

                if (vsync_rise_s) begin
                    frame_done_d  = 1'b1;
                    frame_err_d   = err_d | (y_d != Y_END);
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = bus.enable ? ST_WAIT : ST_IDLE;
                end else if (bus.href) begin
                    if (!phase_q) begin
                        hi_byte_d = bus.p_data;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if ((x_q < X_END) && (y_q < Y_END)) begin
                            pixel_valid_d = 1'b1;
                            pixel_data_d  = {hi_byte_q, bus.p_data};
                            pixel_x_d     = x_q;
                            pixel_y_d     = y_q;
                            pixel_addr_d  = addr_q;
                            x_d           = x_q + 11'd1;
                            addr_d        = (addr_q >= ADDR_END) ? ADDR_END
                                                                 : (addr_q + ADDR_W'(1));
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ACTIVE);
    end

    // State and registered outputs; reset aborts any frame in progress without a frame_done.
    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            phase_q       <= 1'b0;
            hi_byte_q     <= 8'd0;
            x_q           <= 11'd0;
            y_q           <= 11'd0;
            addr_q        <= '0;
            err_q         <= 1'b0;
            pixel_data_q  <= 16'd0;
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= 11'd0;
            pixel_y_q     <= 11'd0;
            pixel_addr_q  <= '0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= 8'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            phase_q       <= phase_d;
            hi_byte_q     <= hi_byte_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_q        <= addr_d;
            err_q         <= err_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pixel_addr_q  <= pixel_addr_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.pixel_data  = pixel_data_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.pixel_x     = pixel_x_q;
    assign bus.pixel_y     = pixel_y_q;
    assign bus.pixel_addr  = pixel_addr_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_count = frame_count_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed bench for ov7670_pixel_capture on a 4x3 frame geometry.
module tb_ov7670_pixel_capture;
    localparam int H = 4;
    localparam int V = 3;
    localparam int AW = 4;

    typedef struct packed {
        logic [15:0]   d;
        logic [10:0]   x;
        logic [10:0]   y;
        logic [AW-1:0] a;
    } pix_t;

    typedef struct packed {
        logic       err;
        logic [7:0] cnt;
    } fd_t;

    logic p_clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   both_cnt;
    pix_t pq[$];
    fd_t  fdq[$];

    ov7670_pixel_capture_if #(.ADDR_W(AW)) bus ();

    ov7670_pixel_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .p_clk (p_clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    // Record every pixel strobe and frame_done pulse, sampled mid-cycle.
    always @(negedge p_clk) begin
        if (bus.pixel_valid) pq.push_back('{bus.pixel_data, bus.pixel_x, bus.pixel_y, bus.pixel_addr});
        if (bus.frame_done) fdq.push_back('{bus.frame_err, bus.frame_count});
        if (bus.pixel_valid && bus.frame_done) both_cnt = both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic vsync_pulse();
        repeat (3) begin
            @(negedge p_clk);
            bus.vsync = 1'b1;
        end
        @(negedge p_clk);
        bus.vsync = 1'b0;
        repeat (3) @(negedge p_clk);
    endtask

    task automatic send_line(input int n, input int base);
        for (int b = 0; b < n; b++) begin
            @(negedge p_clk);
            bus.href   = 1'b1;
            bus.p_data = 8'(base + b);
        end
        @(negedge p_clk);
        bus.href   = 1'b0;
        bus.p_data = 8'd0;
        repeat (3) @(negedge p_clk);
    endtask

    task automatic run_frame(input int nlines, input int nbytes, input int odd_line, input int odd_bytes);
        for (int l = 0; l < nlines; l++) begin
            send_line((l == odd_line) ? odd_bytes : nbytes, l * nbytes);
        end
        vsync_pulse();
    endtask

    task automatic check_frame(input string tag, input int pv_base, input int fd_base,
                               input int exp_pv, input logic [15:0] exp_d0, input logic [15:0] exp_dn,
                               input logic [AW-1:0] exp_an, input logic exp_err, input logic [7:0] exp_cnt);
        pix_t first;
        pix_t last;
        fd_t  fd;
        first = (pq.size() > pv_base) ? pq[pv_base] : '1;
        last  = (pq.size() > pv_base) ? pq[pq.size()-1] : '1;
        fd    = (fdq.size() > fd_base) ? fdq[fdq.size()-1] : '1;
        chk({tag, "_pv_count"}, 32'(pq.size() - pv_base), 32'(exp_pv));
        chk({tag, "_first_data"}, 32'(first.d), 32'(exp_d0));
        chk({tag, "_first_addr"}, 32'(first.a), 32'd0);
        chk({tag, "_last_data"}, 32'(last.d), 32'(exp_dn));
        chk({tag, "_last_addr"}, 32'(last.a), 32'(exp_an));
        chk({tag, "_fd_count"}, 32'(fdq.size() - fd_base), 32'd1);
        chk({tag, "_frame_err"}, 32'(fd.err), 32'(exp_err));
        chk({tag, "_frame_count"}, 32'(fd.cnt), 32'(exp_cnt));
    endtask

    initial begin
        int pvb;
        int fdb;
        pix_t last;
        checks     = 0;
        errors     = 0;
        both_cnt   = 0;
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.vsync  = 1'b0;
        bus.href   = 1'b0;
        bus.p_data = 8'd0;
        repeat (3) @(negedge p_clk);
        chk("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        chk("rst_pixel_data", 32'(bus.pixel_data), 32'd0);
        chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        rst_n = 1'b1;

        // Clean 4x3 frame.
        bus.enable = 1'b1;
        repeat (2) @(negedge p_clk);
        vsync_pulse();
        pvb = pq.size(); fdb = fdq.size();
        send_line(8, 0);
        chk("clean_busy_active", 32'(bus.busy), 32'd1);
        send_line(8, 8);
        send_line(8, 16);
        vsync_pulse();
        check_frame("clean", pvb, fdb, 12, 16'h0001, 16'h1617, 4'd11, 1'b0, 8'd1);
        last = pq[pq.size()-1];
        chk("clean_last_x", 32'(last.x), 32'd3);
        chk("clean_last_y", 32'(last.y), 32'd2);

        // Odd-length middle line: 3 pixels there, addresses continue linearly.
        pvb = pq.size(); fdb = fdq.size();
        run_frame(3, 8, 1, 7);
        check_frame("odd", pvb, fdb, 11, 16'h0001, 16'h1617, 4'd10, 1'b1, 8'd2);

        pvb = pq.size(); fdb = fdq.size();
        run_frame(3, 8, -1, 0);
        check_frame("clean2", pvb, fdb, 12, 16'h0001, 16'h1617, 4'd11, 1'b0, 8'd3);

        // Extra line is suppressed.
        pvb = pq.size(); fdb = fdq.size();
        run_frame(4, 8, -1, 0);
        check_frame("four_lines", pvb, fdb, 12, 16'h0001, 16'h1617, 4'd11, 1'b1, 8'd4);

        // Long lines and extra lines: 5th pixel of each line and lines 4-5 suppressed.
        pvb = pq.size(); fdb = fdq.size();
        run_frame(5, 10, -1, 0);
        check_frame("long", pvb, fdb, 12, 16'h0001, 16'h1A1B, 4'd11, 1'b1, 8'd5);

        // Enable dropped mid-frame: frame still completes, then FSM idles.
        pvb = pq.size(); fdb = fdq.size();
        send_line(8, 0);
        bus.enable = 1'b0;
        send_line(8, 8);
        send_line(8, 16);
        vsync_pulse();
        check_frame("en_drop", pvb, fdb, 12, 16'h0001, 16'h1617, 4'd11, 1'b0, 8'd6);
        chk("en_drop_busy", 32'(bus.busy), 32'd0);
        pvb = pq.size(); fdb = fdq.size();
        run_frame(3, 8, -1, 0);
        chk("disabled_pv", 32'(pq.size() - pvb), 32'd0);
        chk("disabled_fd", 32'(fdq.size() - fdb), 32'd0);

        // Enable raised mid-frame: that partial frame is never captured.
        pvb = pq.size(); fdb = fdq.size();
        send_line(8, 0);
        bus.enable = 1'b1;
        send_line(8, 8);
        send_line(8, 16);
        vsync_pulse();
        chk("partial_pv", 32'(pq.size() - pvb), 32'd0);
        chk("partial_fd", 32'(fdq.size() - fdb), 32'd0);
        run_frame(3, 8, -1, 0);
        check_frame("after_partial", pvb, fdb, 12, 16'h0001, 16'h1617, 4'd11, 1'b0, 8'd7);

        // Reset asserted mid-line, right after a pixel strobe.
        @(negedge p_clk);
        bus.href = 1'b1; bus.p_data = 8'hAA;
        @(negedge p_clk);
        bus.p_data = 8'hBB;
        @(negedge p_clk);
        bus.p_data = 8'hCC;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        chk("midrst_pixel_data", 32'(bus.pixel_data), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_frame_count", 32'(bus.frame_count), 32'd0);
        @(negedge p_clk);
        bus.href = 1'b0;
        rst_n = 1'b1;
        pvb = pq.size(); fdb = fdq.size();
        send_line(8, 0);
        chk("postrst_no_capture", 32'(pq.size() - pvb), 32'd0);
        vsync_pulse();
        chk("postrst_no_fd", 32'(fdq.size() - fdb), 32'd0);
        run_frame(3, 8, -1, 0);
        check_frame("postrst", pvb, fdb, 12, 16'h0001, 16'h1617, 4'd11, 1'b0, 8'd1);

        chk("pv_fd_exclusive", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ov7670_pixel_capture.md
Name: ov7670_pixel_capture

Overview:
Capture front end for the OV7670 parallel bus, clocked by the camera pixel clock. It gates capture to whole frames and assembles byte pairs into RGB565 pixels. Each pixel is tagged with x/y position and a linear frame-buffer address, and the block reports frame completion and geometry errors. Its outputs feed the BRAM write controller, which packs pixels and writes them into the dual-port frame buffer.

Parameters:
H_ACTIVE, 640, pixels per line (2 bytes per pixel on bus)
V_ACTIVE, 480, lines per frame
ADDR_W, 19, width of pixel_addr; must hold H_ACTIVE*V_ACTIVE-1

Ports:
p_clk  in  1  camera pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  capture request (level)
vsync  in  1  camera VSYNC, high = vertical sync
href  in  1  camera HREF, high = valid byte on p_data
p_data  in  8  camera data byte
pixel_data  out  16  RGB565 {R[4:0],G[5:0],B[4:0]}
pixel_valid  out  1  one-cycle strobe, pixel_data/x/y/addr valid
pixel_x  out  11  column of current pixel, 0..H_ACTIVE-1
pixel_y  out  11  line of current pixel, 0..V_ACTIVE-1
pixel_addr  out  ADDR_W  pixel_y*H_ACTIVE+pixel_x
frame_done  out  1  one-cycle strobe at end of captured frame
frame_err  out  1  sticky geometry error for current frame, valid with frame_done
frame_count  out  8  completed frames, wraps 255->0
busy  out  1  high in ACTIVE state

Behaviour:
- Reset: all outputs 0, state IDLE, byte phase 0, all counters 0. Reset asserted mid-frame aborts immediately; no frame_done is issued.
- vsync is registered once (vsync_q); a rising edge is vsync=1 & vsync_q=0, a falling edge the inverse. href and p_data are sampled directly, with no synchroniser (source-synchronous bus).
- FSM states:
  - IDLE: enable=1 -> WAIT_SYNC.
  - WAIT_SYNC: on vsync falling edge -> ACTIVE; clear x, y, addr, phase, err. If enable drops first -> IDLE.
  - ACTIVE: capture. On vsync rising edge: pulse frame_done, increment frame_count, then go to WAIT_SYNC if enable=1, else IDLE.
- Entry requires a full vsync high->low transition; a partial frame after enable is never captured.
- Byte assembly (ACTIVE only), on each edge with href=1:
  - phase 0: latch byte as pixel_data[15:8]; phase becomes 1.
  - phase 1: form {hi_byte, p_data}; phase becomes 0.
- Pixel emission: on the phase-1 edge, if x<H_ACTIVE and y<V_ACTIVE, the registered outputs update and pixel_valid=1 for exactly the next cycle with current x, y, addr. x and addr then increment.
- Latency: pixel_valid rises one p_clk after the second byte is sampled.
- Pixel at x>=H_ACTIVE or y>=V_ACTIVE: suppressed (no pixel_valid, x/addr frozen), and err set.
- Line end (href 1->0 seen on registered href, ACTIVE):
  - phase=1 (odd byte count) -> err; the dangling byte is dropped.
  - x!=H_ACTIVE -> err.
  - Then x=0, phase=0, y+=1 (saturates at V_ACTIVE).
  - addr is not recomputed; it continues linearly, so short/long lines leave addr skewed, flagged by err.
- Frame end (vsync rising in ACTIVE):
  - y!=V_ACTIVE -> err.
  - frame_err is presented with the frame_done pulse and holds until the next frame start clears it.
  - href=1 concurrently with vsync rise: that byte is ignored; frame end takes priority.
- pixel_valid and frame_done are never high in the same cycle; frame_done wins.
- busy=1 exactly while state=ACTIVE.
- Widths: x, y are 11-bit unsigned; addr is ADDR_W-bit; all counters are non-wrapping within a frame (saturate) except frame_count.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=3; enable=1; vsync pulse then 3 lines of 8 bytes 0x00..0x17 -> 12 pixel_valid strobes, first pixel_data=0x0001 addr=0, last 0x1617 addr=11 x=3 y=2; frame_done=1, frame_err=0, frame_count=1.
- enable raised while a frame is in progress (vsync low, href toggling) -> no pixel_valid until after the next full vsync high->low; first captured pixel has addr=0.
- Line with 7 bytes (odd) -> 3 pixels from that line, frame_err=1 at frame_done; next clean frame -> frame_err=0.
- 4 lines instead of 3 -> line 4 emits no pixel_valid, y stays 3, frame_err=1; 5 lines of 10 bytes also -> extra pixel suppressed.
- enable dropped mid-frame -> current frame completes with frame_done, FSM returns to IDLE, busy=0, no further pixel_valid on subsequent frames.
- rst_n pulsed low mid-line -> all outputs 0 immediately; with enable held, capture restarts only after the next vsync falling edge; frame_count restarts at 0.
